// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: assembles 32-bit words from a byte-wide memory.
// Optional next-word prefetch buffer enabled by defining IFETCH_PREFETCH_EN.
module instr_fetch_ctrl #(
    parameter int ADDR_W   = 10,
    parameter int MAX_WAIT = 15
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [31:0]       PC,
    output logic [31:0]       INSTRUCTION,
    output logic              BUSYWAIT,
    output logic              MEM_READ,
    output logic [ADDR_W-1:0] MEM_ADDRESS,
    input  logic [7:0]        MEM_READDATA,
    input  logic              MEM_ACK,
    output logic              FETCH_ERR
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_READ = 2'd1;
    localparam logic [1:0] S_ERR  = 2'd2;
`ifdef IFETCH_PREFETCH_EN
    localparam logic [1:0] S_PREF = 2'd3;
`endif

    logic [1:0]        r_state;
    logic              r_valid;
    logic [ADDR_W-1:0] r_tag;
    logic [31:0]       r_word;
    logic [23:0]       r_asm;
    logic [ADDR_W-3:0] r_base;
    logic [1:0]        r_cnt;
    logic [WAIT_W-1:0] r_wait;

    logic [ADDR_W-1:0] w_pc;
    logic              w_misalign;
    logic              w_hit_main;
    logic              w_hit;
    logic              w_busy_fsm;
    logic              w_last;
    logic              w_timeout;
    logic [31:0]       w_full;
    logic              w_unused_pc;

    assign w_pc        = PC[ADDR_W-1:0];
    assign w_misalign  = PC[1] | PC[0];
    assign w_hit_main  = r_valid && (r_tag == w_pc);
    assign w_last      = (r_cnt == 2'd3);
    assign w_timeout   = (r_wait == WAIT_W'(MAX_WAIT - 1));
    assign w_full      = {MEM_READDATA, r_asm};
    assign w_unused_pc = ^PC;

`ifdef IFETCH_PREFETCH_EN
    logic              r_pvalid;
    logic [ADDR_W-1:0] r_ptag;
    logic [31:0]       r_pword;
    logic              w_hit_pref;
    logic [ADDR_W-1:0] w_next_tag;

    assign w_hit_pref  = r_pvalid && (r_ptag == w_pc);
    assign w_next_tag  = r_tag + ADDR_W'(4);
    assign w_hit       = w_hit_main | w_hit_pref;
    assign w_busy_fsm  = (r_state == S_READ) | (r_state == S_PREF);
    assign INSTRUCTION = (!w_hit_main && w_hit_pref) ? r_pword : r_word;
`else
    assign w_hit       = w_hit_main;
    assign w_busy_fsm  = (r_state == S_READ);
    assign INSTRUCTION = r_word;
`endif

    assign MEM_READ    = w_busy_fsm;
    assign MEM_ADDRESS = {r_base, r_cnt};
    assign FETCH_ERR   = (r_state == S_ERR);
    assign BUSYWAIT    = RESET & (~w_hit | (r_state == S_ERR));

    // Fetch sequencer: byte requests, word assembly, buffer fill and error trap
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_tag   <= '0;
            r_word  <= '0;
            r_asm   <= '0;
            r_base  <= '0;
            r_cnt   <= '0;
            r_wait  <= '0;
`ifdef IFETCH_PREFETCH_EN
            r_pvalid <= 1'b0;
            r_ptag   <= '0;
            r_pword  <= '0;
`endif
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_misalign) begin
                        r_state <= S_ERR;
                    end else if (w_hit_main) begin
`ifdef IFETCH_PREFETCH_EN
                        if (!(r_pvalid && (r_ptag == w_next_tag))) begin
                            r_base  <= w_next_tag[ADDR_W-1:2];
                            r_cnt   <= '0;
                            r_wait  <= '0;
                            r_state <= S_PREF;
                        end
`endif
`ifdef IFETCH_PREFETCH_EN
                    end else if (w_hit_pref) begin
                        r_tag    <= r_ptag;
                        r_word   <= r_pword;
                        r_valid  <= 1'b1;
                        r_ptag   <= r_tag;
                        r_pword  <= r_word;
                        r_pvalid <= r_valid;
`endif
                    end else begin
                        r_base  <= w_pc[ADDR_W-1:2];
                        r_cnt   <= '0;
                        r_wait  <= '0;
                        r_state <= S_READ;
                    end
                end
`ifdef IFETCH_PREFETCH_EN
                S_READ, S_PREF: begin
`else
                S_READ: begin
`endif
                    if (MEM_ACK) begin
                        case (r_cnt)
                            2'd0:    r_asm[7:0]   <= MEM_READDATA;
                            2'd1:    r_asm[15:8]  <= MEM_READDATA;
                            2'd2:    r_asm[23:16] <= MEM_READDATA;
                            default: ;
                        endcase
                        r_cnt  <= r_cnt + 2'd1;
                        r_wait <= '0;
                        if (w_last) begin
                            r_state <= S_IDLE;
`ifdef IFETCH_PREFETCH_EN
                            if (r_state == S_PREF) begin
                                r_ptag   <= {r_base, 2'b00};
                                r_pword  <= w_full;
                                r_pvalid <= 1'b1;
                            end else begin
                                r_tag   <= {r_base, 2'b00};
                                r_word  <= w_full;
                                r_valid <= 1'b1;
                            end
`else
                            r_tag   <= {r_base, 2'b00};
                            r_word  <= w_full;
                            r_valid <= 1'b1;
`endif
                        end
                    end else if (w_timeout) begin
                        r_state <= S_ERR;
                        r_valid <= 1'b0;
`ifdef IFETCH_PREFETCH_EN
                        r_pvalid <= 1'b0;
`endif
                    end else begin
                        r_wait <= r_wait + WAIT_W'(1);
                    end
                end
                S_ERR: begin
                    r_state <= S_ERR;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
